temp_restoring_divider: RTL and testbench

Sequential restoring divider, one quotient bit per clock. It is the inverse of the team's add/sub adder path: it divides an accumulated temperature sum by a sample count (or divisor) to produce averages and ratios. It sits between the temperature accumulator and the display/threshold logic. It uses a start/done handshake, and its results are held until the next accepted start.

---
 rtl/temp_calc_pkg.sv | 23 ++
 rtl/temp_restoring_divider_div_trial_sub.sv | 48 ++++
 rtl/temp_restoring_divider.sv | 136 +++++++++++++
 tb/tb_temp_restoring_divider.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/temp_calc_pkg.sv
// Shared types and helpers for the temperature calculation blocks.
// Optional feature macro used by consumers: TEMP_DIV_SIGNED_EN.
package temp_calc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int TEMP_DIV_W_DEFAULT = 8;

   // Bits needed to hold values 0..value-1 (ceil(log2(value))).
   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << i) < value) res = i + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/temp_restoring_divider_div_trial_sub.sv
// Trial subtractor for the restoring divider: minuend - subtrahend over
// WIDTH+1 bits, rippled through add_sub cells configured for subtraction.

// One-bit add/subtract cell: sel=1 inverts b so that a + ~b + cin subtracts.
module add_sub (
   input  logic a,
   input  logic b,
   input  logic sel,
   input  logic cin,
   output logic sum,
   output logic cout
);
   logic b_eff;

   // Full adder on a and the conditionally inverted b.
   always_comb begin
      b_eff = b ^ sel;
      sum   = a ^ b_eff ^ cin;
      cout  = (a & b_eff) | (a & cin) | (b_eff & cin);
   end
endmodule

module div_trial_sub #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0] minuend,
   input  logic [WIDTH:0] subtrahend,
   output logic [WIDTH:0] diff,
   output logic           borrow
);
   logic [WIDTH+1:0] carry;

   assign carry[0] = 1'b1;

   for (genvar i = 0; i <= WIDTH; i++) begin : g_cell
      add_sub u_cell (
         .a    (minuend[i]),
         .b    (subtrahend[i]),
         .sel  (1'b1),
         .cin  (carry[i]),
         .sum  (diff[i]),
         .cout (carry[i+1])
      );
   end

   // No carry out of the top cell means the subtraction went negative.
   assign borrow = ~carry[WIDTH+1];
endmodule

// File: rtl/temp_restoring_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/done
// handshake, results held until the next accepted start.
// Optional feature macro: TEMP_DIV_SIGNED_EN (two's complement operands).
//
// state | meaning
// IDLE  | waiting for start, results held
// RUN   | one quotient bit resolved per cycle, MSB first
// DONE  | results valid, done pulsed; start here is accepted back-to-back
module temp_restoring_divider
   import temp_calc_pkg::*;
#(
   parameter int WIDTH = TEMP_DIV_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = clog2(WIDTH + 1);

   div_state_t       state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] dvd_sh;   // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] dsr;
   logic [WIDTH-1:0] rem_r;
   logic             accept, zero_div, last_iter, borrow;
   logic [WIDTH:0]   partial, trial;
   logic [WIDTH-1:0] rem_nxt, quo_nxt, rem_fix, quo_fix;
   logic [WIDTH-1:0] dvd_mag, dsr_mag;
   logic             unused_trial_msb;

   assign accept    = start && (state != RUN);
   assign zero_div  = (divisor == '0);
   assign last_iter = (cnt == CW'(1));
   assign busy      = (state == RUN);
   assign done      = (state == DONE);

   assign partial = {rem_r, dvd_sh[WIDTH-1]};

   div_trial_sub #(.WIDTH(WIDTH)) u_trial (
      .minuend    (partial),
      .subtrahend ({1'b0, dsr}),
      .diff       (trial),
      .borrow     (borrow)
   );

   // A non-borrowing trial is below the divisor, so its top bit is always 0.
   assign unused_trial_msb = trial[WIDTH];
   assign rem_nxt = borrow ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
   assign quo_nxt = {dvd_sh[WIDTH-2:0], ~borrow};

`ifdef TEMP_DIV_SIGNED_EN
   logic neg_q, neg_r;

   // Divide magnitudes; the most negative value maps to its unsigned magnitude.
   assign dvd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
   assign dsr_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
   assign quo_fix = neg_q ? (~quo_nxt + 1'b1) : quo_nxt;
   assign rem_fix = neg_r ? (~rem_nxt + 1'b1) : rem_nxt;

   // Operand signs captured at accept drive the fix-up on the last iteration.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (accept) begin
         neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
         neg_r <= dividend[WIDTH-1];
      end
   end
`else
   assign dvd_mag = dividend;
   assign dsr_mag = divisor;
   assign quo_fix = quo_nxt;
   assign rem_fix = rem_nxt;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; divide by zero skips RUN entirely.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (accept) state_nxt = zero_div ? DONE : RUN;
            else        state_nxt = IDLE;
         end
         RUN:     if (last_iter) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, iteration and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt         <= '0;
         dvd_sh      <= '0;
         dsr         <= '0;
         rem_r       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         if (zero_div) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end else begin
            dvd_sh      <= dvd_mag;
            dsr         <= dsr_mag;
            rem_r       <= '0;
            cnt         <= CW'(WIDTH);
            div_by_zero <= 1'b0;
         end
      end else if (state == RUN) begin
         dvd_sh <= quo_nxt;
         rem_r  <= rem_nxt;
         cnt    <= cnt - CW'(1);
         if (last_iter) begin
            quotient  <= quo_fix;
            remainder <= rem_fix;
         end
      end
   end

endmodule

// File: tb/tb_temp_restoring_divider.sv
// Scoreboard bench for temp_restoring_divider (WIDTH=8): directed operations
// push expected results; a monitor pops and compares on every done pulse.
module tb_temp_restoring_divider;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;

   typedef struct packed {
      logic [7:0] q;
      logic [7:0] r;
      logic       z;
   } exp_t;

   exp_t sb[$];
   int   total;
   int   bad;
   bit   drv_done;

`ifdef TEMP_DIV_SIGNED_EN
   localparam logic [7:0] Q200 = 8'hF8;   // -56 / 7 = -8 r 0
   localparam logic [7:0] R200 = 8'h00;
`else
   localparam logic [7:0] Q200 = 8'd28;
   localparam logic [7:0] R200 = 8'd4;
`endif

   temp_restoring_divider #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Waits for done after an accept edge; counts negedges to done and busy cycles.
   task automatic wait_done(input string name, input int lat, input int busy_exp);
      int n;
      int bn;
      bit seen;
      n = 0; bn = 0; seen = 1'b0;
      while (n < 40 && !seen) begin
         @(negedge clk);
         n++;
         start = 1'b0;
         if (busy) bn++;
         if (done) seen = 1'b1;
      end
      check({name, " latency"}, seen ? n : -1, lat);
      check({name, " busy_cycles"}, bn, busy_exp);
   endtask

   task automatic do_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] q, input logic [7:0] r, input logic z);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      sb.push_back('{q: q, r: r, z: z});
      wait_done(name, z ? 1 : 9, z ? 0 : 8);
   endtask

   initial begin
      total = 0; bad = 0; drv_done = 1'b0;
      rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      fork
         begin : driver
            @(negedge clk);
            @(negedge clk);
            check("rst busy", int'(busy), 0);
            check("rst done", int'(done), 0);
            check("rst quotient", int'(quotient), 0);
            check("rst remainder", int'(remainder), 0);
            check("rst dbz", int'(div_by_zero), 0);
            rst_n = 1'b1;
            @(negedge clk);

            do_op("200/7", 8'd200, 8'd7, Q200, R200, 1'b0);
            @(negedge clk);
            do_op("5/0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1);
            do_op("9/3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0);
            do_op("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
            do_op("3/10", 8'd3, 8'd10, 8'd0, 8'd3, 1'b0);
            do_op("10/10", 8'd10, 8'd10, 8'd1, 8'd0, 1'b0);
            @(negedge clk);

            // Re-pulse start with different operands while busy.
            dividend = 8'd100; divisor = 8'd9; start = 1'b1;
            sb.push_back('{q: 8'd11, r: 8'd1, z: 1'b0});
            @(negedge clk); start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            dividend = 8'd50; divisor = 8'd5; start = 1'b1;
            @(negedge clk); start = 1'b0;
            wait_done("100/9 ignore", 5, 4);
            // Start held in the DONE cycle: accepted back-to-back.
            do_op("60/7 b2b", 8'd60, 8'd7, 8'd8, 8'd4, 1'b0);
            do_op("120/16 b2b", 8'd120, 8'd16, 8'd7, 8'd8, 1'b0);
            @(negedge clk);

            // Abort mid-RUN with reset.
            dividend = 8'd200; divisor = 8'd7; start = 1'b1;
            @(negedge clk); start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            check("abort busy", int'(busy), 0);
            check("abort done", int'(done), 0);
            check("abort quotient", int'(quotient), 0);
            check("abort remainder", int'(remainder), 0);
            check("abort dbz", int'(div_by_zero), 0);
            rst_n = 1'b1;
            @(negedge clk);
            do_op("200/7 after abort", 8'd200, 8'd7, Q200, R200, 1'b0);

`ifdef TEMP_DIV_SIGNED_EN
            do_op("-100/7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0);
            do_op("100/-7", 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0);
            do_op("-128/-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
            do_op("-5/0", 8'hFB, 8'd0, 8'hFF, 8'hFB, 1'b1);
`endif
            @(negedge clk);
            @(negedge clk);
            drv_done = 1'b1;
         end
         begin : monitor
            exp_t e;
            while (!drv_done) begin
               @(negedge clk);
               if (rst_n && done) begin
                  if (sb.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL result: done with q=%0d r=%0d dbz=%0d but nothing expected",
                              quotient, remainder, div_by_zero);
                  end else begin
                     e = sb.pop_front();
                     total++;
                     if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.z) begin
                        bad++;
                        $display("FAIL result: got q=%0d r=%0d dbz=%0d expected q=%0d r=%0d dbz=%0d",
                                 quotient, remainder, div_by_zero, e.q, e.r, e.z);
                     end
                  end
               end
            end
         end
      join
      check("scoreboard drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
